// File: rtl/adder_mp_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit carry adder walks the limbs LSB-first.
// Define ADDMP_FLAGS_EN to add the registered out_ovf / out_zero result flags.

module AdderCH32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module adder_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*32-1:0] in_a,
  input  logic [WORDS*32-1:0] in_b,
  input  logic               in_sub,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*32-1:0] out_sum,
  output logic               out_cout
`ifdef ADDMP_FLAGS_EN
  ,
  output logic               out_ovf,
  output logic               out_zero
`endif
);
  localparam int W  = WORDS * 32;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic          valid_q;
  logic [31:0]   op1;
  logic [31:0]   op2;
  logic          add_cin;
  logic [31:0]   sum;
  logic          cout;
  logic          last;

  AdderCH32bit u_adder (
    .a    (op1),
    .b    (op2),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    op1     = '0;
    op2     = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      op1     = a_reg[{idx, 5'd0} +: 32];
      op2     = b_reg[{idx, 5'd0} +: 32];
      add_cin = carry;
    end
  end

  assign last      = (idx == IW'(WORDS - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = valid_q;

`ifdef ADDMP_FLAGS_EN
  logic [W-1:0] res_full;
  logic         ovf_next;
  logic         zero_next;

  // Lower limbs are already final when the top limb is being added.
  always_comb begin
    res_full            = out_sum;
    res_full[W-1 -: 32] = sum;
    zero_next           = (res_full == '0);
    ovf_next            = (a_reg[W-1] == b_reg[W-1]) && (sum[31] != a_reg[W-1]);
  end
`endif

  // out_valid is registered, so it rises one cycle after the last limb lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      carry    <= 1'b0;
      valid_q  <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef ADDMP_FLAGS_EN
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            carry <= in_sub ? ~in_cin : in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) out_sum[i*32 +: 32] <= sum;
          end
          carry <= cout;
          if (last) begin
            out_cout <= cout;
`ifdef ADDMP_FLAGS_EN
            out_ovf  <= ovf_next;
            out_zero <= zero_next;
`endif
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_mp_seq.sv
// Self-checking bench for adder_mp_seq: vector table plus scoreboard, with hand-written
// sequences for backpressure, ignored requests, reset mid-operation and the WORDS=1 build.

module tb_adder_mp_seq;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, in_sub, in_cin;
  logic         out_valid, out_ready, out_cout;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         s_in_valid, s_in_ready, s_in_sub, s_in_cin;
  logic         s_out_valid, s_out_ready, s_out_cout;
  logic [31:0]  s_in_a, s_in_b, s_out_sum;
`ifdef ADDMP_FLAGS_EN
  logic         out_ovf, out_zero, s_out_ovf, s_out_zero;
`endif

  adder_mp_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef ADDMP_FLAGS_EN
    , .out_ovf(out_ovf), .out_zero(out_zero)
`endif
  );

  adder_mp_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_sub(s_in_sub), .in_cin(s_in_cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .out_cout(s_out_cout)
`ifdef ADDMP_FLAGS_EN
    , .out_ovf(s_out_ovf), .out_zero(s_out_zero)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc_cyc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   full;
    bp     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? ~cin : cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    e.zero = (full[W-1:0] == '0);
    e.acc_cyc = 0;
    return e;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input logic cin, input logic [W-1:0] sum, input logic cout);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin; v.sum = sum; v.cout = cout;
    return v;
  endfunction

  task automatic check1(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %0s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request, pushes its expectation, then scrambles inputs after the accept edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                               input logic cin, input logic [W-1:0] esum, input logic ecout);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check1("accept_ready", (W+1)'(in_ready), (W+1)'(1));
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom, $urandom, $urandom};
    in_b = {$urandom, $urandom, $urandom, $urandom};
    in_sub = ~sub; in_cin = ~cin;
    e = model(a, b, sub, cin);
    e.sum = esum;
    e.cout = ecout;
    e.acc_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input bit check_lat);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check1({name, "_valid"}, (W+1)'(out_valid), (W+1)'(1));
    if (sb.size() == 0) begin
      check1({name, "_sb_empty"}, (W+1)'(1), (W+1)'(0));
    end else begin
      e = sb.pop_front();
      if (check_lat) check1({name, "_lat"}, (W+1)'(cyc - e.acc_cyc), (W+1)'(WORDS + 1));
      check1({name, "_sum"}, {1'b0, out_sum}, {1'b0, e.sum});
      check1({name, "_cout"}, (W+1)'(out_cout), (W+1)'(e.cout));
`ifdef ADDMP_FLAGS_EN
      check1({name, "_ovf"}, (W+1)'(out_ovf), (W+1)'(e.ovf));
      check1({name, "_zero"}, (W+1)'(out_zero), (W+1)'(e.zero));
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check1({name, "_drop"}, (W+1)'(out_valid), (W+1)'(0));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] maxpos;
    logic [W-1:0] ra, rb;
    exp_t         m;
    int           n, acc;

    ones   = '1;
    maxpos = {1'b0, {(W-1){1'b1}}};
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_sub = 1'b0; s_in_cin = 1'b0; s_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
    check1("rst_out_valid", (W+1)'(out_valid), (W+1)'(0));
    check1("rst_out_sum", {1'b0, out_sum}, '0);
    check1("rst_out_cout", (W+1)'(out_cout), (W+1)'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0] = mk(ones, W'(1), 1'b0, 1'b0, '0, 1'b1);
    vecs[1] = mk('0, W'(1), 1'b1, 1'b0, ones, 1'b0);
    vecs[2] = mk(W'(5), W'(3), 1'b1, 1'b0, W'(2), 1'b1);
    vecs[3] = mk(128'h00000000_FFFFFFFF_00000000_FFFFFFFF, W'(1), 1'b0, 1'b1,
                 128'h00000000_FFFFFFFF_00000001_00000001, 1'b0);
    vecs[4] = mk(maxpos, W'(1), 1'b0, 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0);
    vecs[5] = mk(W'(10), W'(3), 1'b1, 1'b1, W'(6), 1'b1);
    for (int i = 6; i < 10; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      m  = model(ra, rb, i[0], i[1]);
      vecs[i] = mk(ra, rb, i[0], i[1], m.sum, m.cout);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, vecs[i].sum, vecs[i].cout);
      checkOutput($sformatf("vec%0d", i), 1'b1);
    end

    // Backpressure with stray requests during RUN and DONE.
    applyStimulus(W'(123), W'(456), 1'b0, 1'b0, W'(579), 1'b0);
    in_valid = 1'b1; in_a = W'(7); in_b = W'(7);
    @(posedge clk); #1;
    check1("run_in_ready", (W+1)'(in_ready), (W+1)'(0));
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int k = 0; k < 10; k++) begin
      in_valid = (k == 3);
      @(posedge clk); #1;
      check1($sformatf("hold_valid%0d", k), (W+1)'(out_valid), (W+1)'(1));
      check1($sformatf("hold_sum%0d", k), {1'b0, out_sum}, (W+1)'(579));
    end
    check1("done_in_ready", (W+1)'(in_ready), (W+1)'(0));
    in_valid = 1'b0;
    checkOutput("hold", 1'b0);
    check1("idle_in_ready", (W+1)'(in_ready), (W+1)'(1));
    repeat (8) @(posedge clk);
    #1;
    check1("no_stray_op", (W+1)'(out_valid), (W+1)'(0));

    // Reset while limb 2 is being processed.
    applyStimulus(ones, ones, 1'b0, 1'b1, ones, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check1("midrst_out_valid", (W+1)'(out_valid), (W+1)'(0));
    check1("midrst_out_sum", {1'b0, out_sum}, '0);
    check1("midrst_in_ready", (W+1)'(in_ready), (W+1)'(1));
    void'(sb.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(W'(100), W'(58), 1'b1, 1'b0, W'(42), 1'b1);
    checkOutput("after_rst", 1'b1);

    // Single-limb instance.
    s_in_a = '1; s_in_b = 32'd1; s_in_sub = 1'b0; s_in_cin = 1'b0; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    acc = cyc;
    n = 0;
    while (!s_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check1("w1_lat", (W+1)'(cyc - acc), (W+1)'(2));
    check1("w1_sum", (W+1)'(s_out_sum), '0);
    check1("w1_cout", (W+1)'(s_out_cout), (W+1)'(1));
`ifdef ADDMP_FLAGS_EN
    check1("w1_zero", (W+1)'(s_out_zero), (W+1)'(1));
    check1("w1_ovf", (W+1)'(s_out_ovf), (W+1)'(0));
`endif
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    check1("w1_drop", (W+1)'(s_out_valid), (W+1)'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
